// File: rtl/pwm_pkg.sv
// Shared definitions for the duty ramp controller: FSM states, the rate
// select encoding and the prescaler tick-period table.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  typedef enum logic [1:0] {
    RATE_1    = 2'd0,
    RATE_16   = 2'd1,
    RATE_256  = 2'd2,
    RATE_4096 = 2'd3
  } rate_sel_e;

  // Prescaler counter width; holds the largest terminal count (4095).
  localparam int PRESC_W = 12;

  // Tick period in clock cycles for each rate_sel code.
  localparam int TICK_PERIOD [4] = '{1, 16, 256, 4096};

  // Terminal count of the prescaler (period - 1) for a given rate.
  function automatic logic [PRESC_W-1:0] tick_last(input rate_sel_e rate);
    return PRESC_W'(TICK_PERIOD[int'(rate)] - 1);
  endfunction

endpackage

// File: rtl/ramp_prescaler.sv
// Tick prescaler for the duty ramp: counts while enabled and emits a
// one-cycle tick when the count reaches period-1, then wraps to zero.
module ramp_prescaler
  import pwm_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      enable,
  input  rate_sel_e rate,
  output logic      tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               at_last;

  assign at_last = (cnt_q == tick_last(rate));
  // A clear wins over counting so a fresh start always restarts the period.
  assign tick    = enable && !clear && at_last;

  // Next count: clear, wrap at the terminal count, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Duty ramp controller: slews the PWM duty word toward a latched target in
// steps of at most STEP, one step per prescaler tick, and pulses done when
// the target is reached.
// Optional target clamp to MAX_DUTY is built when DUTY_CLAMP_EN is defined.
module duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int STEP        = 1,
  parameter int MAX_DUTY    = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] target_duty,
  input  logic [1:0]             rate_sel,
  output logic [WORD_LENGTH-1:0] duty_out,
  output logic                   busy,
  output logic                   done,
  output logic                   clamped
);

`ifdef DUTY_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam int                   WP1    = WORD_LENGTH + 1;
  localparam logic [WORD_LENGTH:0] STEP_X = WP1'(STEP);
  localparam logic [WORD_LENGTH-1:0] STEP_N = WORD_LENGTH'(STEP);

  ramp_state_e            state_q;
  rate_sel_e              rate_q;
  logic [WORD_LENGTH-1:0] duty_q;
  logic [WORD_LENGTH-1:0] tgt_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   clamped_q;

  logic                   over_max;
  logic [WORD_LENGTH-1:0] tgt_in;
  logic [WORD_LENGTH:0]   gap_up;
  logic [WORD_LENGTH:0]   gap_dn;
  logic [WORD_LENGTH-1:0] step_d;
  logic                   tick;

  // Target selection; with the clamp disabled over_max folds to zero.
  always_comb begin
    over_max = CLAMP_EN && (int'(target_duty) > MAX_DUTY);
    tgt_in   = over_max ? WORD_LENGTH'(MAX_DUTY) : target_duty;
  end

  // One bounded step toward the target; gaps are computed one bit wider so
  // the comparison against STEP can neither wrap nor overshoot.
  always_comb begin
    gap_up = {1'b0, tgt_q} - {1'b0, duty_q};
    gap_dn = {1'b0, duty_q} - {1'b0, tgt_q};
    step_d = duty_q;
    if (tgt_q > duty_q) begin
      step_d = (gap_up <= STEP_X) ? tgt_q : duty_q + STEP_N;
    end else if (tgt_q < duty_q) begin
      step_d = (gap_dn <= STEP_X) ? tgt_q : duty_q - STEP_N;
    end
  end

  ramp_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .enable (state_q == RAMP),
    .rate   (rate_q),
    .tick   (tick)
  );

  // Ramp FSM with registered outputs; start has priority in both states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rate_q    <= RATE_1;
      duty_q    <= '0;
      tgt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        tgt_q     <= tgt_in;
        rate_q    <= rate_sel_e'(rate_sel);
        clamped_q <= over_max;
        if (tgt_in == duty_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= RAMP;
          busy_q  <= 1'b1;
        end
      end else if (state_q == RAMP && tick) begin
        duty_q <= step_d;
        if (step_d == tgt_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign clamped  = clamped_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Bench for duty_ramp_ctrl: two instances (STEP=1 and STEP=4) share stimulus.
// Directed vector table, hand sequences for multi-cycle corners, then random
// starts checked against a cycle-level behavioural model.
module tb_duty_ramp_ctrl;

  localparam int W    = 8;
  localparam int MAXD = 100;
`ifdef DUTY_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] target_duty;
  logic [1:0]   rate_sel;
  logic [W-1:0] duty1, duty4;
  logic         busy1, busy4, done1, done4, clamped1, clamped4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  duty_ramp_ctrl #(.WORD_LENGTH(W), .STEP(1), .MAX_DUTY(MAXD)) dut1 (
    .clk(clk), .reset(reset), .start(start), .target_duty(target_duty),
    .rate_sel(rate_sel), .duty_out(duty1), .busy(busy1), .done(done1),
    .clamped(clamped1)
  );

  duty_ramp_ctrl #(.WORD_LENGTH(W), .STEP(4), .MAX_DUTY(MAXD)) dut4 (
    .clk(clk), .reset(reset), .start(start), .target_duty(target_duty),
    .rate_sel(rate_sel), .duty_out(duty4), .busy(busy4), .done(done4),
    .clamped(clamped4)
  );

  typedef struct {
    bit start;
    int target;
    int rate;
    int d1; bit b1; bit n1;
    int d4; bit b4; bit n4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit s, input int t, input int r,
                              input int d1, input bit b1, input bit n1,
                              input int d4, input bit b4, input bit n4);
    vec_t v;
    v.start = s; v.target = t; v.rate = r;
    v.d1 = d1; v.b1 = b1; v.n1 = n1;
    v.d4 = d4; v.b4 = b4; v.n4 = n4;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, let one active edge pass, settle 1 ns past it.
  task automatic tick(input bit s, input int t, input int r);
    start       = s;
    target_duty = W'(t);
    rate_sel    = 2'(r);
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int STEPS [2] = '{1, 4};
  int m_duty [2], m_tgt [2], m_period [2], m_elapsed [2];
  bit m_active [2], m_done [2], m_clamped [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_duty[i] = 0; m_tgt[i] = 0; m_period[i] = 1; m_elapsed[i] = 0;
      m_active[i] = 0; m_done[i] = 0; m_clamped[i] = 0;
    end
  endfunction

  // One clock edge: the duty moves once every `period` cycles since the
  // last start, by at most STEP, never past the target.
  function automatic void model_edge(input bit s, input int t, input int r);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (s) begin
        m_clamped[i] = CLAMP && (t > MAXD);
        m_tgt[i]     = m_clamped[i] ? MAXD : t;
        m_period[i]  = 1 << (4 * r);
        m_elapsed[i] = 0;
        m_active[i]  = (m_tgt[i] != m_duty[i]);
        m_done[i]    = !m_active[i];
      end else if (m_active[i]) begin
        m_elapsed[i]++;
        if (m_elapsed[i] % m_period[i] == 0) begin
          int diff = m_tgt[i] - m_duty[i];
          if (diff < 0 ? -diff <= STEPS[i] : diff <= STEPS[i])
            m_duty[i] = m_tgt[i];
          else
            m_duty[i] += (diff > 0) ? STEPS[i] : -STEPS[i];
          if (m_duty[i] == m_tgt[i]) begin
            m_active[i] = 0;
            m_done[i]   = 1;
          end
        end
      end
    end
  endfunction

  task automatic do_reset();
    start = 0; target_duty = '0; rate_sel = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int  dcount;
  int  k;
  int  ceil_exp;
  bit  s;
  int  t, r;

  initial begin
    reset = 1'b0; start = 0; target_duty = '0; rate_sel = '0;
    #12;
    chk("reset_duty1", int'(duty1), 0);
    chk("reset_busy1", int'(busy1), 0);
    chk("reset_done1", int'(done1), 0);
    chk("reset_clamped1", int'(clamped1), 0);
    chk("reset_duty4", int'(duty4), 0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- vector table ----------------
    vecs.push_back(mk(1, 10, 0, 0, 1, 0, 0, 1, 0));
    for (int i = 1; i <= 11; i++)
      vecs.push_back(mk(0, 0, 0, (i < 10) ? i : 10, i < 10, i == 10,
                        (i == 1) ? 4 : (i == 2) ? 8 : 10, i < 3, i == 3));
    vecs.push_back(mk(1, 0, 0, 10, 1, 0, 10, 1, 0));
    for (int i = 1; i <= 11; i++)
      vecs.push_back(mk(0, 0, 0, (i < 10) ? 10 - i : 0, i < 10, i == 10,
                        (i == 1) ? 6 : (i == 2) ? 2 : 0, i < 3, i == 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].start, vecs[i].target, vecs[i].rate);
      $display("vec %0d: start=%0d tgt=%0d duty1=%0d duty4=%0d", i,
               vecs[i].start, vecs[i].target, duty1, duty4);
      chk($sformatf("vec%0d_duty1", i), int'(duty1), vecs[i].d1);
      chk($sformatf("vec%0d_busy1", i), int'(busy1), int'(vecs[i].b1));
      chk($sformatf("vec%0d_done1", i), int'(done1), int'(vecs[i].n1));
      chk($sformatf("vec%0d_duty4", i), int'(duty4), vecs[i].d4);
      chk($sformatf("vec%0d_busy4", i), int'(busy4), int'(vecs[i].b4));
      chk($sformatf("vec%0d_done4", i), int'(done4), int'(vecs[i].n4));
    end

    // ---------------- rate 01: steps only every 16 cycles ----------------
    tick(1, 3, 1);
    $display("seq rate16: start tgt=3 duty1=%0d", duty1);
    chk("r16_start_duty", int'(duty1), 0);
    for (int i = 1; i <= 50; i++) begin
      tick(0, 0, 0);
      chk($sformatf("r16_duty_%0d", i), int'(duty1), (i < 48) ? i / 16 : 3);
      chk($sformatf("r16_done_%0d", i), int'(done1), int'(i == 48));
    end

    // ---------------- async reset mid-ramp ----------------
    tick(1, 200, 0);
    k = 0;
    while (duty1 != 37 && k < 300) begin
      tick(0, 0, 0);
      k++;
    end
    chk("mid_reach37", int'(duty1), 37);
    #2;
    reset = 1'b0;
    #1;
    $display("seq reset: reset asserted between edges duty1=%0d", duty1);
    chk("mid_rst_duty1", int'(duty1), 0);
    chk("mid_rst_busy1", int'(busy1), 0);
    chk("mid_rst_duty4", int'(duty4), 0);
    chk("mid_rst_busy4", int'(busy4), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0);
      chk($sformatf("post_rst_duty_%0d", i), int'(duty1), 0);
      chk($sformatf("post_rst_busy_%0d", i), int'(busy1), 0);
    end

    // ---------------- retarget mid-ramp ----------------
    tick(1, 200, 0);
    k = 0; dcount = 0;
    while (duty1 != 50 && k < 300) begin
      tick(0, 0, 0);
      dcount += int'(done1);
      k++;
    end
    chk("rt_reach50", int'(duty1), 50);
    tick(1, 20, 0);
    $display("seq retarget: start tgt=20 at duty1=%0d", duty1);
    dcount += int'(done1);
    chk("rt_hold_duty", int'(duty1), 50);
    chk("rt_hold_busy", int'(busy1), 1);
    for (int i = 1; i <= 36; i++) begin
      tick(0, 0, 0);
      dcount += int'(done1);
      chk($sformatf("rt_duty_%0d", i), int'(duty1), (50 - i >= 20) ? 50 - i : 20);
      chk($sformatf("rt_done_%0d", i), int'(done1), int'(i == 30));
    end
    chk("rt_done_count", dcount, 1);
    chk("rt_busy_end", int'(busy1), 0);

    // ---------------- start with target == duty ----------------
    tick(1, 20, 0);
    $display("seq equal: start tgt=20 duty1=%0d", duty1);
    chk("eq_done", int'(done1), 1);
    chk("eq_busy", int'(busy1), 0);
    chk("eq_duty", int'(duty1), 20);
    tick(0, 0, 0);
    chk("eq_done_clear", int'(done1), 0);
    chk("eq_busy_after", int'(busy1), 0);

    // ---------------- clamp behaviour ----------------
    ceil_exp = CLAMP ? MAXD : 255;
    tick(1, 255, 0);
    $display("seq clamp: start tgt=255 clamped1=%0d", clamped1);
    chk("cl_clamped", int'(clamped1), int'(CLAMP));
    dcount = 0;
    for (int i = 0; i < 260; i++) begin
      tick(0, 0, 0);
      dcount += int'(done1);
    end
    chk("cl_final", int'(duty1), ceil_exp);
    chk("cl_done_count", dcount, 1);
    chk("cl_clamped_hold", int'(clamped1), int'(CLAMP));
    tick(1, 50, 0);
    chk("cl_clamped_clear", int'(clamped1), 0);
    k = 0;
    while (busy1 && k < 300) begin
      tick(0, 0, 0);
      k++;
    end
    chk("cl_reach50", int'(duty1), 50);

    // ---------------- random starts vs model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      s = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 3) == 0) ? m_duty[c % 2] : int'($urandom_range(0, 255));
      k = int'($urandom_range(0, 19));
      r = (k < 12) ? 0 : (k < 17) ? 1 : (k < 19) ? 2 : 3;
      tick(s, t, r);
      model_edge(s, t, r);
      if (s)
        $display("rand %0d: start tgt=%0d rate=%0d duty1=%0d duty4=%0d",
                 c, t, r, duty1, duty4);
      chk($sformatf("rand%0d_duty1", c), int'(duty1), m_duty[0]);
      chk($sformatf("rand%0d_busy1", c), int'(busy1), int'(m_active[0]));
      chk($sformatf("rand%0d_done1", c), int'(done1), int'(m_done[0]));
      chk($sformatf("rand%0d_clamped1", c), int'(clamped1), int'(m_clamped[0]));
      chk($sformatf("rand%0d_duty4", c), int'(duty4), m_duty[1]);
      chk($sformatf("rand%0d_busy4", c), int'(busy4), int'(m_active[1]));
      chk($sformatf("rand%0d_done4", c), int'(done4), int'(m_done[1]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_ramp_ctrl.md
Name: duty_ramp_ctrl

Overview:
- Upstream stage of the PWM generator: produces the duty-cycle word that the PWM consumes.
- Accepts a target duty via a start strobe and slews its output toward the target in bounded steps at a selectable rate.
- Purpose: soft-start and soft-retarget, so the PWM never sees an abrupt duty jump.
- Signals completion with a one-cycle done pulse.

Parameters:
- WORD_LENGTH, 8, width of duty words; matches the PWM dutyCycle input.
- STEP, 1, maximum duty change per tick; 1 ≤ STEP < 2^WORD_LENGTH.
- MAX_DUTY, 100, clamp ceiling for the target; used only when DUTY_CLAMP_EN is defined.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle strobe; latches target_duty and rate_sel.
- target_duty  input  WORD_LENGTH  requested final duty.
- rate_sel  input  2  tick period select, P = 2^(4*rate_sel) cycles: 00→1, 01→16, 10→256, 11→4096.
- duty_out  output  WORD_LENGTH  current duty; drives PWM dutyCycle.
- busy  output  1  high while ramping.
- done  output  1  one-cycle pulse when duty_out reaches the target.
- clamped  output  1  latched target was reduced by the clamp.

Behaviour:
- Design style:
  - One clock, clk.
  - reset is asynchronous, active-low.
  - All outputs are registered.
- Reset (reset=0, effective immediately, no clock edge needed):
  - state=IDLE, duty_out=0, busy=0, done=0, clamped=0.
  - Latched target=0, prescaler=0.
- FSM states: IDLE, RAMP.
- start sampled high at edge E0, in either state:
  - Latch tgt=target_duty (clamped when enabled) and P from rate_sel.
  - Clear the prescaler.
  - If tgt==duty_out: done=1 during the cycle after E0; state stays or becomes IDLE; busy=0.
  - Otherwise: state=RAMP, busy=1.
  - A start during RAMP retargets. duty_out continues from its current value, the prescaler restarts, and no done pulse is issued for the abandoned target.
- RAMP, each edge:
  - If cnt==P-1: cnt=0 and apply one step.
  - Else: cnt=cnt+1.
  - First step lands at edge E0+P; subsequent steps every P cycles.
- Step arithmetic (comparison done at WORD_LENGTH+1 bits; no wrap, no overshoot):
  - Up: duty_out = (tgt-duty_out ≤ STEP) ? tgt : duty_out+STEP.
  - Down: duty_out = (duty_out-tgt ≤ STEP) ? tgt : duty_out-STEP.
- Completion:
  - On the edge a step makes duty_out==tgt: state=IDLE, busy=0, done=1.
  - done clears on the next edge unless a new start completes immediately.
- start held high for several cycles: each cycle is treated as a new start, so the prescaler is held cleared and no step occurs.
- In IDLE, duty_out holds its value indefinitely.

Optional Feature:
- Macro: DUTY_CLAMP_EN.
- Defined:
  - Latched tgt = min(target_duty, MAX_DUTY).
  - clamped=1 when target_duty > MAX_DUTY, updated on every start, held until the next start or reset.
- Undefined:
  - tgt = target_duty, MAX_DUTY ignored.
  - clamped tied to 0.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, RAMP}.
  - rate_sel encoding enum.
  - localparam tick-period table (1, 16, 256, 4096).
  - Prescaler counter width constant (12 bits).
- Natural sub-module: ramp_prescaler.
  - Inputs: clk, reset, clear, enable, rate.
  - Output: one-cycle tick at count P-1.
  - Parent holds the FSM and step datapath.

Test Plan:
- Defaults, after reset: start, target=10, rate=00 → duty_out 1,2,…,10 at edges E0+1…E0+10; busy high 10 cycles; done high exactly one cycle after E0+10.
- rate=01, target=3 from 0 → duty_out changes only at E0+16, +32, +48; final value 3; done once.
- STEP=4: target 10 from 0 → 4, 8, 10 (no overshoot). Then target 0 → 6, 2, 0.
- target=200 rate=00; start with target=20 when duty_out=50 → next step 49 at E1+1, descends to 20; single done pulse, none at 200. Separately, start with target==duty_out → done one cycle, busy never high.
- Drop reset low mid-ramp (duty_out=37) between edges → duty_out=0, busy=0 immediately; after release, IDLE with no spontaneous steps.
- DUTY_CLAMP_EN, MAX_DUTY=100: target=255 → ramps to 100, clamped=1, done once. Then target=50 → clamped=0. Without the macro, target=255 → reaches 255, clamped stays 0.
